// File: rtl/lzd_norm_shifter_if.sv
// Handshake bundle between an operand source, the normalization shifter and its consumer.
// Input side: in_valid/in_ready with in_data (operand), in_p (LZD count), in_v (LZD valid).
// Output side: out_valid/out_ready with out_data, out_p, out_zero, plus the sticky err flag.
interface lzd_norm_shifter_if #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CW-1:0]    in_p;
  logic             in_v;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_p;
  logic             out_zero;
  logic             err;

  // master drives operands and accepts results; slave is the shifter itself
  modport master (
    output in_valid, in_data, in_p, in_v, out_ready,
    input  in_ready, out_valid, out_data, out_p, out_zero, err
  );

  modport slave (
    input  in_valid, in_data, in_p, in_v, out_ready,
    output in_ready, out_valid, out_data, out_p, out_zero, err
  );
endinterface

// File: rtl/lzd_norm_shifter.sv
// Pipelined normalization shifter: left-shifts an operand by its LZD count, one count bit per stage.
// Latency: CW register stages (accept at edge N, result presented after edge N+CW-1).
// Backpressure: per-stage ready = !vld || downstream ready, so bubbles fill; in_ready drops only when all stages hold data and out_ready=0.
// Ports: clk, rst_n (async active-low) plus bus (slave modport of lzd_norm_shifter_if).
module lzd_norm_shifter #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lzd_norm_shifter_if.slave     bus
);

  logic [CW-1:0]    vld_q;
  logic [WIDTH-1:0] data_q [CW];
  logic [CW-1:0]    p_q    [CW];
  logic [CW-1:0]    zero_q;
  logic             err_q;

  // Per-stage source values (what stage k would load) and the shifted result
  logic [CW-1:0]    src_v;
  logic [WIDTH-1:0] src_d  [CW];
  logic [CW-1:0]    src_p  [CW];
  logic [CW-1:0]    src_z;
  logic [WIDTH-1:0] data_d [CW];
  logic [CW-1:0]    load;
  logic [CW-1:0]    adv;
  logic             in_rdy;

  always_comb begin
    logic all_v;
    logic dn_rdy;
    logic stg_rdy;
    load   = '0;
    adv    = '0;
    in_rdy = 1'b0;
    all_v  = 1'b1;
    dn_rdy = 1'b0;
    stg_rdy = 1'b0;

    // Stage 0 sources from the input; an all-zero operand is forced to data=0, p=0
    src_v    = '0;
    src_z    = '0;
    src_v[0] = bus.in_valid;
    src_d[0] = bus.in_v ? bus.in_data : '0;
    src_p[0] = bus.in_v ? bus.in_p : '0;
    src_z[0] = !bus.in_v;
    for (int k = 1; k < CW; k++) begin
      src_v[k] = vld_q[k-1];
      src_d[k] = data_q[k-1];
      src_p[k] = p_q[k-1];
      src_z[k] = zero_q[k-1];
    end

    for (int k = 0; k < CW; k++) begin
      // Downstream of stage k is ready if out_ready or any later stage has a bubble
      all_v = 1'b1;
      for (int j = k + 1; j < CW; j++) begin
        all_v = all_v & vld_q[j];
      end
      dn_rdy  = bus.out_ready || !all_v;
      stg_rdy = !vld_q[k] || dn_rdy;
      adv[k]  = vld_q[k] && dn_rdy;
      load[k] = src_v[k] && stg_rdy;
      if (k == 0) begin
        in_rdy = stg_rdy;
      end
      // MSB of the count is handled first so the largest shift sits at the front
      data_d[k] = src_p[k][CW-1-k] ? (src_d[k] << (2 ** (CW - 1 - k))) : src_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      zero_q <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < CW; k++) begin
        data_q[k] <= '0;
        p_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < CW; k++) begin
        if (load[k]) begin
          vld_q[k]  <= 1'b1;
          data_q[k] <= data_d[k];
          p_q[k]    <= src_p[k];
          zero_q[k] <= src_z[k];
        end else if (adv[k]) begin
          vld_q[k]  <= 1'b0;
        end
      end
      // A non-zero result whose MSB is clear means the LZD count was wrong
      if (vld_q[CW-1] && bus.out_ready && !zero_q[CW-1] && !data_q[CW-1][WIDTH-1]) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q[CW-1];
  assign bus.out_data  = data_q[CW-1];
  assign bus.out_p     = p_q[CW-1];
  assign bus.out_zero  = zero_q[CW-1];
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lzd_norm_shifter.sv
// Bench for lzd_norm_shifter at WIDTH=8: a queue-based model predicts every result,
// a negedge monitor compares outputs each cycle, and directed vectors pin literal values.
module tb_lzd_norm_shifter;
  localparam int W = 8;
  localparam int C = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lzd_norm_shifter_if #(.WIDTH(W), .CW(C)) bus ();
  lzd_norm_shifter #(.WIDTH(W), .CW(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_del = 0;

  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [W-1:0] d;
    logic [C-1:0] p;
    logic         z;
  } res_t;

  res_t q[$];
  int   dcyc[$];
  logic model_err = 1'b0;
  logic prev_stall = 1'b0;

  // Normalized result from first principles: shift by the count, or all-zero marker
  function automatic res_t model(input logic [W-1:0] d, input logic [C-1:0] p, input logic v);
    res_t r;
    if (!v) begin
      r.d = '0; r.p = '0; r.z = 1'b1;
    end else begin
      r.d = d << p; r.p = p; r.z = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [C-1:0] lzc(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return C'(W - 1 - i);
    end
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s", nm);
  endtask

  // Per-cycle compare against the model queue (queue = beats accepted but not yet delivered)
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      model_err  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(bus.out_ready || (q.size() < C)));
      if (prev_stall) chk("stall_keeps_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          fail_now("spurious_out_valid with nothing in flight");
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(q[0].d));
          chk("out_p", 32'(bus.out_p), 32'(q[0].p));
          chk("out_zero", 32'(bus.out_zero), 32'(q[0].z));
        end
      end
      chk("err", 32'(bus.err), 32'(model_err));
      prev_stall = bus.out_valid && !bus.out_ready;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        if (!q[0].z && !q[0].d[W-1]) model_err = 1'b1;
        dcyc.push_back(cyc);
        n_del++;
        void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_data, bus.in_p, bus.in_v));
        n_acc++;
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the accepting edge
  task automatic send(input logic [W-1:0] d, input logic [C-1:0] p, input logic v, output int tries);
    bit ok;
    ok = 1'b0;
    tries = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_p = p; bus.in_v = v;
    while (!ok && tries < 60) begin
      @(negedge clk);
      tries++;
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) fail_now("send_timeout waiting for in_ready");
  endtask

  // Returns at the negedge where out_valid is seen; n = negedges waited
  task automatic wait_out(output res_t r, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
    r.d = bus.out_data; r.p = bus.out_p; r.z = bus.out_zero;
    if (!bus.out_valid) fail_now("wait_out_timeout");
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] d; logic [C-1:0] p; logic v;
    logic [W-1:0] ed; logic [C-1:0] ep; logic ez;
  } vec_t;

  vec_t bvec[3];
  int   t, n, ts;
  res_t r;
  logic [W-1:0] rd;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_p = '0; bus.in_v = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_p", 32'(bus.out_p), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Basic: 0x13 with count 3 -> 0x98, three cycles after accept
    send(8'h13, 3'd3, 1'b1, t);
    wait_out(r, n);
    chk("basic_latency", 32'(n), 32'd3);
    chk("basic_data", 32'(r.d), 32'h98);
    chk("basic_p", 32'(r.p), 32'd3);
    chk("basic_zero", 32'(r.z), 32'd0);
    step();

    // Boundaries
    bvec[0] = '{8'h80, 3'd0, 1'b1, 8'h80, 3'd0, 1'b0};
    bvec[1] = '{8'h01, 3'd7, 1'b1, 8'h80, 3'd7, 1'b0};
    bvec[2] = '{8'h00, 3'd5, 1'b0, 8'h00, 3'd0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(bvec[i].d, bvec[i].p, bvec[i].v, t);
      wait_out(r, n);
      chk("bound_data", 32'(r.d), 32'(bvec[i].ed));
      chk("bound_p", 32'(r.p), 32'(bvec[i].ep));
      chk("bound_zero", 32'(r.z), 32'(bvec[i].ez));
      step();
    end
    idle(1);
    chk("bound_err_clear", 32'(bus.err), 32'd0);

    // Streaming: 16 back-to-back nonzero beats
    dcyc.delete();
    for (int i = 0; i < 16; i++) begin
      rd = W'($urandom_range(1, 255));
      send(rd, lzc(rd), 1'b1, t);
      chk("stream_first_try", 32'(t), 32'd1);
    end
    idle(6);
    chk("stream_count", 32'(dcyc.size()), 32'd16);
    if (dcyc.size() == 16) chk("stream_consecutive", 32'(dcyc[15] - dcyc[0]), 32'd15);
    chk("stream_err_clear", 32'(bus.err), 32'd0);

    // Backpressure: fill with out_ready=0
    bus.out_ready = 1'b0;
    send(8'h21, 3'd2, 1'b1, t);
    send(8'h12, 3'd3, 1'b1, t);
    send(8'h09, 3'd4, 1'b1, t);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_held_data", 32'(bus.out_data), 32'h84);
    step();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rd = W'($urandom_range(1, 255));
          send(rd, lzc(rd), 1'b1, ts);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          bus.out_ready = ~bus.out_ready;
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    idle(8);
    chk("bp_no_loss", 32'(n_del), 32'(n_acc));
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Bad count: 0x13 with count 2 -> 0x4C and sticky err
    send(8'h13, 3'd2, 1'b1, t);
    wait_out(r, n);
    chk("bad_data", 32'(r.d), 32'h4C);
    chk("bad_err_before", 32'(bus.err), 32'd0);
    step();
    @(negedge clk);
    chk("bad_err_set", 32'(bus.err), 32'd1);
    step();
    send(8'h40, 3'd1, 1'b1, t);
    send(8'h03, 3'd6, 1'b1, t);
    idle(5);
    chk("bad_err_sticky", 32'(bus.err), 32'd1);

    // Reset with three beats in flight
    bus.out_ready = 1'b0;
    send(8'h11, 3'd3, 1'b1, t);
    send(8'h22, 3'd2, 1'b1, t);
    send(8'h44, 3'd1, 1'b1, t);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n = n_del;
    idle(6);
    chk("arst_no_stale", 32'(n_del), 32'(n));
    send(8'h01, 3'd7, 1'b1, t);
    wait_out(r, n);
    chk("arst_recover_data", 32'(r.d), 32'h80);
    step();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lzd_norm_shifter.md
# lzd_norm_shifter

Pipelined normalization shifter: the consumer end of the leading-zero-detector datapath. It takes an operand with its leading-zero count `p` and valid flag `v` from an `lzd_*` tree, left-shifts the operand by the count so the leading one lands in the MSB, and checks that the count was correct. It sits between the LZD and the rounding/packing stage of the floating-point units. Input and output use valid/ready handshakes, and throughput is one operand per cycle.

## Interface
- `WIDTH`, default 32: operand width. Power of two, ≥ 4.
- `CW`, default $clog2(WIDTH): count width, matching the LZD `p` output.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: stage 0 can accept a beat.
- `in_data` input WIDTH: un-normalized operand.
- `in_p` input CW: leading-zero count from the LZD.
- `in_v` input 1: LZD valid. 1 means `in_data` has at least one set bit.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output WIDTH: normalized operand.
- `out_p` output CW: shift amount applied.
- `out_zero` output 1: operand was all zero (`in_v`=0).
- `err` output 1: sticky flag, set when a normalized result's MSB is not 1.

## Operation
- The pipeline has CW register stages, S0 to S(CW-1).
- Stage k shifts its data left by 2^(CW-1-k) when bit (CW-1-k) of the carried count is 1. Otherwise it passes the data unchanged.
- The shift is logical: zeros are filled in from the LSB side, and bits shifted out of the MSB are discarded.
- Each stage holds: `vld`, `data`, `p`, `zero`.
- Capture into S0 on `in_valid && in_ready`:
  - `zero` = !`in_v`.
  - When `in_v`=0, `data` and `p` are forced to 0, so all-zero operands pass through unshifted with `out_p`=0.
- Stage k+1 loads from stage k when S(k).vld && (!S(k+1).vld || S(k+1) advances).
- The last stage advances when `out_ready`=1.
- `ready` into each stage is !vld || (downstream ready). This lets a bubble be filled under backpressure.
- `in_ready` is the combinational ready of S0.
- Outputs `out_valid`, `out_data`, `out_p` and `out_zero` come directly from S(CW-1) registers.
- Error check:
  - When S(CW-1) is accepted (`out_valid && out_ready`) with `zero`=0 and `out_data[WIDTH-1]`=0, `err` sets to 1.
  - `err` stays 1 until reset.
  - Results are still delivered unchanged after an error.
- Reset values while `rst_n`=0:
  - All `vld` bits = 0, all `data`/`p`/`zero` = 0.
  - `out_valid`=0, `out_data`=0, `out_p`=0, `out_zero`=0, `err`=0.
  - `in_ready`=1.
- Reset mid-operation discards every beat in flight. No partial result is emitted.

## Timing
- Latency: a beat accepted at edge N appears on `out_valid` after edge N+CW-1, so it is presented in the cycle following that edge (CW register stages).
- Throughput is 1 beat/cycle while `out_ready`=1.
- Backpressure:
  - With `out_ready`=0 the pipeline fills. Once every stage is valid, `in_ready` drops to 0 in the same cycle, combinationally from `out_ready`.
  - A stalled output holds `out_data`, `out_p` and `out_zero` stable until accepted.
  - `out_valid` never drops without a handshake.
- Simultaneous accept and load in the same stage is legal. The stage takes the new beat on the same edge.
- `in_data`, `in_p` and `in_v` are sampled only on handshake edges. Their values at other times are don't-care.
- `err` updates on the edge of the offending handshake and is visible the next cycle.

## Test plan
- WIDTH=8, `out_ready`=1. Send `in_data`=0x13, `in_p`=3, `in_v`=1. Required: `out_data`=0x98, `out_p`=3, `out_zero`=0, appearing CW=3 cycles after the accept. `err` stays 0.
- Boundaries at WIDTH=8:
  - `in_data`=0x80, `in_p`=0: `out_data`=0x80.
  - `in_data`=0x01, `in_p`=7: `out_data`=0x80.
  - `in_data`=0x00, `in_v`=0 with any `in_p`: `out_data`=0x00, `out_p`=0, `out_zero`=1, `err`=0.
- Streaming: 16 back-to-back random nonzero beats with correct counts. Required: 16 results in order on consecutive cycles, each with MSB=1, and `in_ready` held at 1 throughout.
- Backpressure: hold `out_ready`=0 while driving continuous beats.
  - Required: `in_ready` falls to 0 once 3 beats are held, and the held output is stable.
  - Then toggle `out_ready` 1/0. Required: no loss or duplication, order preserved.
- Bad count: send `in_data`=0x13 with `in_p`=2. Required: `out_data`=0x4C, then `err`=1 the cycle after the accept, still 1 after further good beats.
- Reset with 3 beats in flight: assert `rst_n`=0 asynchronously mid-cycle. Required:
  - `out_valid`=0, `in_ready`=1 and `err`=0 immediately.
  - No stale results after `rst_n` rises.
